fetch_icache: RTL and testbench

- Fetch stage that feeds the F→D pipeline register.
- Holds the program counter, computes PC+4, and selects the branch redirect.
- Looks up the instruction in a direct-mapped instruction cache.
- On a miss, raises Mem_Stall, which freezes the whole pipeline, and refills one line from main memory over a req/valid handshake.

---
 rtl/fetch_icache.sv | 144 ++++++++++++++
 tb/tb_fetch_icache.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_icache.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_icache
//  Description : Fetch stage with program counter, PC+4 / redirect select and
//                a direct-mapped instruction cache. A miss raises Mem_Stall
//                and refills one full line from memory over req/valid.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_icache #(
  parameter int          LINES          = 16,
  parameter int          WORDS_PER_LINE = 4,
  parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] InstructionF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        Mem_Stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;

  localparam logic [31:0]      C_NOP       = 32'h0000_0013;
  localparam logic [OFF_W-1:0] C_LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [31:0]        r_pcf;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [31:0]        r_data [LINES][WORDS_PER_LINE];
  logic [OFF_W-1:0]   r_beat;
  logic [31:0]        r_mem_addr;

  logic [OFF_W-1:0]   w_off;
  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [31:0]        w_pc_plus4;
  logic               w_hit;
  logic               w_beat_we;
  logic               w_last_beat;

  // PC field split; the index and tag stay stable through a refill because
  // the PC is frozen while Mem_Stall is high.
  assign w_off      = r_pcf[2 +: OFF_W];
  assign w_idx      = r_pcf[2 + OFF_W +: IDX_W];
  assign w_tag      = r_pcf[31 -: TAG_W];
  assign w_pc_plus4 = r_pcf + 32'd4;

  // A hit is only reported from IDLE so a line being refilled never hits.
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag) && (r_state == ST_IDLE);
  assign w_beat_we   = (r_state == ST_REFILL) && mem_valid;
  assign w_last_beat = w_beat_we && (r_beat == C_LAST_BEAT);

  assign InstructionF = w_hit ? r_data[w_idx][w_off] : C_NOP;
  assign PCF          = r_pcf;
  assign PCPlus4F     = w_pc_plus4;
  assign Mem_Stall    = !w_hit;
  // Derived from the state so an asynchronous reset drops it immediately.
  assign mem_req      = (r_state == ST_REFILL);
  assign mem_addr     = r_mem_addr;

  // Program counter: hold on any stall, otherwise take redirect or PC+4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcf <= RESET_PC;
    end else if (!(Mem_Stall || StallF)) begin
      r_pcf <= PCSrcE ? PCTargetE : w_pc_plus4;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: leave IDLE on a miss, return after the last beat lands.
  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_IDLE) begin
      if (!w_hit) begin
        w_state_next = ST_REFILL;
      end
    end else begin
      if (w_last_beat) begin
        w_state_next = ST_IDLE;
      end
    end
  end

  // Refill bookkeeping: line address capture, beat counter and valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= '0;
      r_beat     <= '0;
      r_mem_addr <= '0;
    end else if (r_state == ST_IDLE) begin
      r_beat <= '0;
      if (!w_hit) begin
        r_mem_addr <= {r_pcf[31:2+OFF_W], {OFF_W{1'b0}}, 2'b00};
      end
    end else begin
      if (w_beat_we) begin
        // Power-of-two line length, so the counter wraps to 0 on the last beat.
        r_beat <= r_beat + OFF_W'(1);
      end
      if (w_last_beat) begin
        r_valid[w_idx] <= 1'b1;
      end
    end
  end

  // Data and tag arrays; a partial line is harmless because valid stays low.
  always_ff @(posedge clk) begin
    if (w_beat_we) begin
      r_data[w_idx][r_beat] <= mem_rdata;
    end
    if (w_last_beat) begin
      r_tag[w_idx] <= w_tag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_icache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_icache
//  Description : Scoreboard bench for fetch_icache with a memory responder
//                (3-cycle latency, optional gaps between beats).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_icache;

  logic        clk;
  logic        rst_n;
  logic        StallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstructionF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        Mem_Stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_valid;

  int          tests;
  int          fails;
  logic [31:0] exp_q [$];
  logic [31:0] mon_pc;
  int          rsp_wait;
  int          rsp_beat;
  int          rsp_count;
  bit          gappy;

  fetch_icache dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .StallF       (StallF),
    .PCSrcE       (PCSrcE),
    .PCTargetE    (PCTargetE),
    .InstructionF (InstructionF),
    .PCF          (PCF),
    .PCPlus4F     (PCPlus4F),
    .Mem_Stall    (Mem_Stall),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_valid    (mem_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image seen by the refill port.
  function automatic logic [31:0] img(input logic [31:0] a);
    case (a)
      32'h0:   img = 32'h0050_0093;
      32'h4:   img = 32'h0010_0113;
      32'h8:   img = 32'h0020_81B3;
      32'hC:   img = 32'h0000_0013;
      default: img = {16'hA5A5, a[15:0]};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: got no event within 300 cycles, expected one", nm);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pc(input logic [31:0] pc, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (PCF == pc && !Mem_Stall) ok = 1'b1;
    end
    if (!ok) timeout(nm);
  endtask

  task automatic wait_req(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (mem_req) ok = 1'b1;
    end
    if (!ok) timeout(nm);
  endtask

  task automatic wait_nostall(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (!Mem_Stall) ok = 1'b1;
    end
    if (!ok) timeout(nm);
  endtask

  task automatic wait_beats(input int n, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (rsp_beat == n) ok = 1'b1;
    end
    if (!ok) timeout(nm);
  endtask

  // Memory responder: 3 idle cycles after mem_req, then 4 beats in order.
  initial begin
    mem_valid = 1'b0;
    mem_rdata = '0;
    rsp_wait  = 0;
    rsp_beat  = 0;
    rsp_count = 0;
    forever begin
      @(negedge clk);
      if (!mem_req) begin
        mem_valid = 1'b0;
        rsp_wait  = 0;
        rsp_beat  = 0;
      end else if (rsp_beat >= 4) begin
        mem_valid = 1'b0;
      end else if (rsp_wait < 3) begin
        mem_valid = 1'b0;
        rsp_wait++;
      end else if (gappy && mem_valid) begin
        mem_valid = 1'b0;
      end else begin
        mem_valid = 1'b1;
        mem_rdata = img(mem_addr + 32'(rsp_beat * 4));
        rsp_beat++;
        rsp_count++;
      end
    end
  end

  // Monitor: every consumed fetch is compared against the next expected PC.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && !Mem_Stall && !StallF && exp_q.size() > 0) begin
        mon_pc = exp_q.pop_front();
        chk("fetch_pc", PCF, mon_pc);
        chk("fetch_instr", InstructionF, img(mon_pc));
        chk("fetch_pc4", PCPlus4F, mon_pc + 32'd4);
      end
    end
  end

  // Stimulus.
  initial begin
    tests     = 0;
    fails     = 0;
    gappy     = 1'b0;
    rst_n     = 1'b0;
    StallF    = 1'b0;
    PCSrcE    = 1'b0;
    PCTargetE = '0;

    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h8, 32'hC, 32'h10, 32'h4, 32'h8,
              32'hC, 32'h10, 32'h14, 32'h100, 32'h104, 32'h0, 32'h4, 32'h8};

    // Reset and cold miss.
    repeat (3) begin
      tick();
      chk("rst_pcf", PCF, 32'h0);
      chk("rst_pc4", PCPlus4F, 32'h4);
      chk("rst_req", 32'(mem_req), 32'h0);
    end
    rst_n = 1'b1;
    #1;
    chk("cold_stall", 32'(Mem_Stall), 32'h1);
    chk("cold_req_low", 32'(mem_req), 32'h0);
    tick();
    chk("cold_req", 32'(mem_req), 32'h1);
    chk("cold_addr", mem_addr, 32'h0);
    wait_nostall("cold_refill");
    chk("cold_beats", 32'(rsp_count), 32'd4);
    chk("cold_first_instr", InstructionF, 32'h0050_0093);

    // StallF hold at PC 0x4.
    wait_pc(32'h4, "reach_4");
    StallF = 1'b1;
    repeat (4) begin
      tick();
      chk("stallf_pcf", PCF, 32'h4);
      chk("stallf_instr", InstructionF, 32'h0010_0113);
      chk("stallf_req", 32'(mem_req), 32'h0);
    end
    StallF = 1'b0;
    tick();
    chk("stallf_release", PCF, 32'h8);

    // Branch on a hit.
    wait_pc(32'hC, "reach_c");
    PCSrcE    = 1'b1;
    PCTargetE = 32'h8;
    tick();
    chk("br_pcf", PCF, 32'h8);
    chk("br_pc4", PCPlus4F, 32'hC);
    chk("br_stall", 32'(Mem_Stall), 32'h0);
    PCSrcE = 1'b0;

    // Line crossing miss with a redirect held during the refill.
    wait_req("req_10");
    chk("cross_addr", mem_addr, 32'h10);
    chk("cross_pcf", PCF, 32'h10);
    gappy     = 1'b1;
    PCSrcE    = 1'b1;
    PCTargetE = 32'h4;
    wait_nostall("refill_10");
    chk("cross_hit_pcf", PCF, 32'h10);
    tick();
    chk("redir_after_refill", PCF, 32'h4);
    PCSrcE = 1'b0;
    gappy  = 1'b0;

    // Conflict miss: 0x100 evicts line 0.
    wait_pc(32'h14, "reach_14");
    PCSrcE    = 1'b1;
    PCTargetE = 32'h100;
    tick();
    PCSrcE = 1'b0;
    chk("evict_pcf", PCF, 32'h100);
    chk("evict_stall", 32'(Mem_Stall), 32'h1);
    wait_req("req_100");
    chk("evict_addr", mem_addr, 32'h100);

    // Back to 0x0 misses again, then reset aborts that refill after 2 beats.
    wait_pc(32'h104, "reach_104");
    PCSrcE    = 1'b1;
    PCTargetE = 32'h0;
    tick();
    PCSrcE = 1'b0;
    chk("remiss_stall", 32'(Mem_Stall), 32'h1);
    wait_req("req_0_again");
    chk("remiss_addr", mem_addr, 32'h0);
    wait_beats(2, "two_beats");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_req", 32'(mem_req), 32'h0);
    chk("abort_pcf", PCF, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    chk("abort_stall", 32'(Mem_Stall), 32'h1);
    wait_req("req_after_abort");
    chk("abort_addr", mem_addr, 32'h0);

    // Let the monitor drain the remaining expected fetches.
    begin
      bit done;
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
        tick();
        if (exp_q.size() == 0) done = 1'b1;
      end
    end
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
